itu_scheduler: RTL and testbench
================================

ITU_SCHEDULER -- requirements
Module: itu_scheduler

Interface
REQ-001 Parameter MUL_LATENCY, default 3, sets multiplier issue-to-writeback cycles; legal range 2..DIV_LATENCY-1.
REQ-002 Parameter DIV_LATENCY, default 34, sets divider issue-to-writeback cycles; legal range greater than MUL_LATENCY.
REQ-003 clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 rst_i  in  1  reset, synchronous, active-high.
REQ-005 flush_i  in  1  pipeline flush; cancels all in-flight reservations.
REQ-006 issue_valid_i  in  1  an integer operation is presented.
REQ-007 issue_unit_i  in  3  target unit, one-hot {ALU, MUL, DIV}, ALU is MSB, same order as the ITU valid vector.
REQ-008 issue_ready_o  out  1  operation accepted this cycle when high with issue_valid_i.
REQ-009 alu_valid_o / mul_valid_o / div_valid_o  out  1 each  dispatch strobes to the subunits.
REQ-010 div_abort_o  out  1  kills the iterative divider.
REQ-011 div_busy_o  out  1  divider has an operation in flight.
REQ-012 wb_valid_o  out  1  a subunit result occupies the shared writeback port this cycle.
REQ-013 wb_select_o  out  3  one-hot {ALU, MUL, DIV} writeback mux select; all zero when wb_valid_o is low.

Function
REQ-014 Unit latency L: ALU 1, MUL MUL_LATENCY, DIV DIV_LATENCY; an operation dispatched in cycle t writes back in cycle t+L exactly.
REQ-015 State is a reservation shift register r[0..DIV_LATENCY-1] with valid bit and 3-bit unit tag per slot; r[k] means writeback k cycles from now.
REQ-016 Each cycle r[k] <= r[k+1] for k < DIV_LATENCY-1 and r[DIV_LATENCY-1] <= empty, then on dispatch r[L-1] <= {valid, unit}.
REQ-017 Slot index DIV_LATENCY is treated as always free.
REQ-018 issue_ready_o = !flush_i and issue_unit_i one-hot and r[L] free and (unit != DIV or !div_busy_o); combinational.
REQ-019 Non-one-hot issue_unit_i (including zero) gives issue_ready_o low and no dispatch strobe.
REQ-020 Dispatch strobe for unit U = issue_valid_i and issue_ready_o and issue_unit_i[U]; at most one strobe per cycle.
REQ-021 wb_valid_o = r[0].valid and wb_select_o = r[0].tag, both driven from registers, no combinational input path.
REQ-022 Divider FSM states IDLE and BUSY: IDLE->BUSY on div_valid_o; BUSY->IDLE after the DIV writeback cycle (counter loaded with DIV_LATENCY-1, decremented each cycle, exit when it reaches 0 while wb_select_o = DIV); div_busy_o high in BUSY only.
REQ-023 A new DIV is accepted in the cycle after the previous DIV writes back; it is never accepted during that DIV's writeback cycle.
REQ-024 flush_i: the next cycle all r slots are empty and the FSM is IDLE; the writeback in the flush cycle itself still appears on wb_valid_o / wb_select_o.
REQ-025 div_abort_o = flush_i and div_busy_o, combinational.
REQ-026 flush_i and issue_valid_i in the same cycle: flush wins; no dispatch and no reservation.
REQ-027 Back-to-back ALU dispatches every cycle are legal when no MUL/DIV slot collides; collision on r[L] stalls only the colliding request.

Reset
REQ-028 While rst_i is high at a clock edge: all r slots empty and FSM IDLE, taking priority over flush_i and dispatch.
REQ-029 After reset: wb_valid_o 0, wb_select_o 000, div_busy_o 0, div_abort_o 0, issue_ready_o follows REQ-018.
REQ-030 Reset asserted mid-division discards the operation without asserting div_abort_o.

Verification (MUL_LATENCY=3, DIV_LATENCY=34)
REQ-031 MUL at cycle 0, then ALU every cycle -> ALU accepted cycles 1, 3+; cycle 2 ALU stalled (slot 3 taken by MUL); wb_select_o = MUL at cycle 3.
REQ-032 DIV at cycle 0, second DIV held valid -> div_busy_o high cycles 1..34, wb_select_o = DIV at 34, second DIV accepted at 35.
REQ-033 DIV at cycle 0, flush_i at cycle 10 -> div_abort_o high at 10, div_busy_o low at 11, no writeback at 34.
REQ-034 flush_i and ALU issue in the same cycle -> issue_ready_o 0, alu_valid_o 0, no writeback next cycle.
REQ-035 issue_unit_i = 101 or 000 with issue_valid_i -> issue_ready_o 0, no strobes, reservations unchanged.
REQ-036 rst_i at cycle 5 with MUL and DIV in flight -> from cycle 6 wb_valid_o 0, div_busy_o 0, and a DIV issue is accepted.

Source files
------------

// File: rtl/itu_scheduler.sv
// Integer-unit writeback scheduler.
// Tracks future writeback-port usage in a reservation shift register so that ALU, MUL and DIV
// results never collide on the shared writeback port, and sequences the iterative divider.
module itu_scheduler #(
   parameter int unsigned MUL_LATENCY = 3,
   parameter int unsigned DIV_LATENCY = 34
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       flush_i,
   input  logic       issue_valid_i,
   input  logic [2:0] issue_unit_i,
   output logic       issue_ready_o,
   output logic       alu_valid_o,
   output logic       mul_valid_o,
   output logic       div_valid_o,
   output logic       div_abort_o,
   output logic       div_busy_o,
   output logic       wb_valid_o,
   output logic [2:0] wb_select_o
);

   // Unit encodings, ALU in the MSB.
   localparam logic [2:0] UnitAlu = 3'b100;
   localparam logic [2:0] UnitMul = 3'b010;
   localparam logic [2:0] UnitDiv = 3'b001;

   localparam int unsigned CntW = (DIV_LATENCY > 2) ? $clog2(DIV_LATENCY) : 1;

   typedef enum logic [0:0] {
      StIdle,
      StBusy
   } div_state_e;

   // Slot k describes the writeback k cycles from now.
   logic [DIV_LATENCY-1:0]      slot_valid_q;
   logic [DIV_LATENCY-1:0][2:0] slot_tag_q;

   div_state_e      div_state_q;
   logic [CntW-1:0] div_cnt_q;

   logic target_free;
   logic dispatch;

   assign div_busy_o  = (div_state_q == StBusy);
   assign div_abort_o = flush_i & div_busy_o;

   assign wb_valid_o  = slot_valid_q[0];
   assign wb_select_o = slot_tag_q[0];

   // Acceptance: the slot that will shift into r[L-1] must be free; non-one-hot codes never match.
   always_comb begin
      target_free = 1'b0;
      case (issue_unit_i)
         UnitAlu: target_free = ~slot_valid_q[1];
         UnitMul: target_free = ~slot_valid_q[MUL_LATENCY];
         // r[DIV_LATENCY] is always free, so only the iterative divider itself can block.
         UnitDiv: target_free = ~div_busy_o;
         default: target_free = 1'b0;
      endcase
      issue_ready_o = ~flush_i & target_free;
   end

   assign dispatch    = issue_valid_i & issue_ready_o;
   assign alu_valid_o = dispatch & issue_unit_i[2];
   assign mul_valid_o = dispatch & issue_unit_i[1];
   assign div_valid_o = dispatch & issue_unit_i[0];

   // Reservation shift register: advance one slot per cycle, then insert the new dispatch.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         slot_valid_q <= '0;
         slot_tag_q   <= '0;
      end else if (flush_i) begin
         slot_valid_q <= '0;
         slot_tag_q   <= '0;
      end else begin
         for (int k = 0; k < int'(DIV_LATENCY) - 1; k++) begin
            slot_valid_q[k] <= slot_valid_q[k+1];
            slot_tag_q[k]   <= slot_tag_q[k+1];
         end
         slot_valid_q[DIV_LATENCY-1] <= 1'b0;
         slot_tag_q[DIV_LATENCY-1]   <= 3'b000;

         // The checked slot was free, so overwriting the shifted-in value loses nothing.
         if (alu_valid_o) begin
            slot_valid_q[0] <= 1'b1;
            slot_tag_q[0]   <= UnitAlu;
         end
         if (mul_valid_o) begin
            slot_valid_q[MUL_LATENCY-1] <= 1'b1;
            slot_tag_q[MUL_LATENCY-1]   <= UnitMul;
         end
         if (div_valid_o) begin
            slot_valid_q[DIV_LATENCY-1] <= 1'b1;
            slot_tag_q[DIV_LATENCY-1]   <= UnitDiv;
         end
      end
   end

   // Divider sequencer: busy from the cycle after dispatch through the DIV writeback cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         div_state_q <= StIdle;
         div_cnt_q   <= '0;
      end else if (flush_i) begin
         div_state_q <= StIdle;
         div_cnt_q   <= '0;
      end else begin
         case (div_state_q)
            StIdle: begin
               if (div_valid_o) begin
                  div_state_q <= StBusy;
                  div_cnt_q   <= CntW'(DIV_LATENCY - 1);
               end
            end
            StBusy: begin
               if (div_cnt_q != '0) begin
                  div_cnt_q <= div_cnt_q - 1'b1;
               end else if (wb_select_o == UnitDiv) begin
                  // Counter expiry lines up with the DIV result sitting in r[0].
                  div_state_q <= StIdle;
               end
            end
            default: begin
               div_state_q <= StIdle;
               div_cnt_q   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_itu_scheduler.sv
// Self-checking bench for itu_scheduler: a reference model built from writeback times
// predicts acceptance, strobes and divider status; a monitor matches writebacks to a scoreboard.
module tb_itu_scheduler;

   localparam int unsigned MulLat = 3;
   localparam int unsigned DivLat = 34;

   localparam logic [2:0] Alu = 3'b100;
   localparam logic [2:0] Mul = 3'b010;
   localparam logic [2:0] Div = 3'b001;

   logic       clk = 1'b0;
   logic       rst_i;
   logic       flush_i;
   logic       issue_valid_i;
   logic [2:0] issue_unit_i;
   logic       issue_ready_o;
   logic       alu_valid_o;
   logic       mul_valid_o;
   logic       div_valid_o;
   logic       div_abort_o;
   logic       div_busy_o;
   logic       wb_valid_o;
   logic [2:0] wb_select_o;

   itu_scheduler #(
      .MUL_LATENCY(MulLat),
      .DIV_LATENCY(DivLat)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .flush_i      (flush_i),
      .issue_valid_i(issue_valid_i),
      .issue_unit_i (issue_unit_i),
      .issue_ready_o(issue_ready_o),
      .alu_valid_o  (alu_valid_o),
      .mul_valid_o  (mul_valid_o),
      .div_valid_o  (div_valid_o),
      .div_abort_o  (div_abort_o),
      .div_busy_o   (div_busy_o),
      .wb_valid_o   (wb_valid_o),
      .wb_select_o  (wb_select_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         wb;
      logic [2:0] unit;
   } wb_t;

   wb_t sb[$];              // accepted operations awaiting writeback
   int  div_until = -1;     // last cycle the divider reports busy
   int  vectors = 0;
   int  miscompares = 0;
   bit  mon_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic bit slot_taken(input int t);
      foreach (sb[i]) if (sb[i].wb == t) return 1'b1;
      return 1'b0;
   endfunction

   // One clock cycle of stimulus plus model prediction and checking of combinational outputs.
   task automatic step(input bit v, input logic [2:0] u, input bit f, input bit r);
      int         now;
      int         lat;
      bit         onehot;
      bit         busy;
      bit         free;
      bit         exp_ready;
      bit         exp_go;
      logic [2:0] exp_strobe;
      @(posedge clk);
      #1;
      issue_valid_i = v;
      issue_unit_i  = u;
      flush_i       = f;
      rst_i         = r;
      now    = cyc;
      onehot = (u == Alu) || (u == Mul) || (u == Div);
      busy   = (div_until >= now);
      lat    = (u == Alu) ? 1 : (u == Mul) ? int'(MulLat) : int'(DivLat);
      if (u == Div) free = !busy;
      else          free = !slot_taken(now + lat);
      exp_ready  = !f && onehot && free;
      exp_go     = v && exp_ready;
      exp_strobe = exp_go ? u : 3'b000;
      @(negedge clk);
      check("issue_ready", issue_ready_o, exp_ready);
      check("strobes", {alu_valid_o, mul_valid_o, div_valid_o}, exp_strobe);
      check("div_busy", div_busy_o, busy);
      check("div_abort", div_abort_o, f && busy);
      if (r || f) begin
         for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].wb > now) sb.delete(i);
         div_until = -1;
      end else if (exp_go) begin
         sb.push_back('{wb: now + lat, unit: u});
         if (u == Div) div_until = now + int'(DivLat);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 3'b000, 1'b0, 1'b0);
   endtask

   // Writeback monitor: every cycle the port must carry exactly the scheduled result, if any.
   always @(negedge clk) begin
      int         idx;
      logic       exp_v;
      logic [2:0] exp_sel;
      if (mon_en) begin
         idx     = -1;
         exp_v   = 1'b0;
         exp_sel = 3'b000;
         foreach (sb[i]) if (sb[i].wb == cyc) idx = i;
         if (idx >= 0) begin
            exp_v   = 1'b1;
            exp_sel = sb[idx].unit;
            sb.delete(idx);
         end
         check("wb_valid", wb_valid_o, exp_v);
         check("wb_select", wb_select_o, exp_sel);
      end
   end

   initial begin
      logic [2:0] bad_codes[5];
      logic [2:0] u;
      int         pick;
      bit         v;
      bit         f;
      bit         r;
      bad_codes = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};

      rst_i         = 1'b1;
      flush_i       = 1'b0;
      issue_valid_i = 1'b0;
      issue_unit_i  = 3'b000;
      repeat (3) @(posedge clk);
      mon_en = 1'b1;

      // Reset state, then MUL followed by a stream of ALU requests (one ALU stall).
      idle(2);
      step(1'b1, Mul, 1'b0, 1'b0);
      repeat (6) step(1'b1, Alu, 1'b0, 1'b0);
      idle(4);

      // DIV with a second DIV held until the first has written back.
      step(1'b1, Div, 1'b0, 1'b0);
      repeat (37) step(1'b1, Div, 1'b0, 1'b0);
      idle(40);

      // DIV flushed mid-flight.
      step(1'b1, Div, 1'b0, 1'b0);
      idle(9);
      step(1'b0, 3'b000, 1'b1, 1'b0);
      idle(30);

      // Flush coinciding with an ALU issue.
      step(1'b1, Alu, 1'b1, 1'b0);
      idle(2);

      // Illegal unit codes must not disturb an in-flight MUL.
      step(1'b1, Mul, 1'b0, 1'b0);
      step(1'b1, 3'b101, 1'b0, 1'b0);
      step(1'b1, 3'b000, 1'b0, 1'b0);
      idle(4);

      // Reset with MUL and DIV in flight, then a DIV is accepted straight away.
      step(1'b1, Div, 1'b0, 1'b0);
      step(1'b1, Mul, 1'b0, 1'b0);
      idle(1);
      step(1'b0, 3'b000, 1'b0, 1'b1);
      step(1'b1, Div, 1'b0, 1'b0);
      idle(40);

      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         pick = int'($urandom_range(0, 9));
         if (pick <= 3)      u = Alu;
         else if (pick <= 6) u = Mul;
         else if (pick == 7) u = Div;
         else                u = bad_codes[$urandom_range(0, 4)];
         v = ($urandom_range(0, 99) < 75);
         f = ($urandom_range(0, 99) < 3);
         r = ($urandom_range(0, 299) == 0);
         if (r) begin
            v = 1'b0;
            f = 1'b0;
         end
         step(v, u, f, r);
      end

      idle(40);
      check("scoreboard_drained", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
